// File: rtl/axi_sram_slave.sv
// AXI3-style 32-bit SRAM slave with independent single-outstanding read and write engines.
// Optional read stall insertion enabled by defining AXI_SRAM_RSTALL_EN.
module axi_sram_slave #(
  parameter int unsigned MEM_AW = 14,
  parameter logic [31:0] BASE   = 32'h1FC0_0000
) (
  input  logic        aclk,
  input  logic        aresetn,
  // read address
  input  logic [3:0]  arid,
  input  logic [31:0] araddr,
  input  logic [7:0]  arlen,
  input  logic [2:0]  arsize,
  input  logic [1:0]  arburst,
  input  logic [1:0]  arlock,
  input  logic [3:0]  arcache,
  input  logic [2:0]  arprot,
  input  logic        arvalid,
  output logic        arready,
  // read data
  output logic [3:0]  rid,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rlast,
  output logic        rvalid,
  input  logic        rready,
  // write address
  input  logic [3:0]  awid,
  input  logic [31:0] awaddr,
  input  logic [7:0]  awlen,
  input  logic [2:0]  awsize,
  input  logic [1:0]  awburst,
  input  logic [1:0]  awlock,
  input  logic [3:0]  awcache,
  input  logic [2:0]  awprot,
  input  logic        awvalid,
  output logic        awready,
  // write data
  input  logic [3:0]  wid,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wlast,
  input  logic        wvalid,
  output logic        wready,
  // write response
  output logic [3:0]  bid,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready
);

  localparam int unsigned DEPTH       = 1 << MEM_AW;
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;
  localparam logic [1:0]  BURST_FIXED = 2'b00;

  typedef enum logic [1:0] {R_IDLE, R_DATA, R_GAP} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;

  logic [31:0] mem [DEPTH];

  r_state_t    r_state;
  logic [31:0] rd_addr;
  logic [7:0]  rd_len;
  logic [7:0]  rd_cnt;
  logic [1:0]  rd_burst;

  w_state_t    w_state;
  logic [3:0]  wr_id;
  logic [31:0] wr_addr;
  logic [7:0]  wr_len;
  logic [7:0]  wr_cnt;
  logic [1:0]  wr_burst;
  logic        wr_err;

  logic [31:0] rd_addr_nxt_c;
  logic [31:0] wr_addr_nxt_c;
  logic        ar_in_c;
  logic        rd_nxt_in_c;
  logic        wr_in_c;
  logic        wr_last_c;
  logic        wr_fire_c;
  logic        wr_bad_c;
  logic        we_c;
  logic        unused_sigs;

  // FIXED bursts hold the address, every other burst type increments by one word
  assign rd_addr_nxt_c = (rd_burst == BURST_FIXED) ? rd_addr : rd_addr + 32'd4;
  assign wr_addr_nxt_c = (wr_burst == BURST_FIXED) ? wr_addr : wr_addr + 32'd4;

  assign ar_in_c     = (araddr[31:MEM_AW+2] == BASE[31:MEM_AW+2]);
  assign rd_nxt_in_c = (rd_addr_nxt_c[31:MEM_AW+2] == BASE[31:MEM_AW+2]);
  assign wr_in_c     = (wr_addr[31:MEM_AW+2] == BASE[31:MEM_AW+2]);

  assign wr_last_c = (wr_cnt == wr_len);
  assign wr_fire_c = wvalid && wready;
  assign wr_bad_c  = !wr_in_c || (wlast != wr_last_c);
  assign we_c      = wr_fire_c && wr_in_c;

  assign unused_sigs = ^{arlock, arcache, arprot, arsize,
                         awlock, awcache, awprot, awsize, wid};

  // Byte-lane write port; contents survive reset
  always_ff @(posedge aclk) begin
    if (we_c) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb[b]) mem[wr_addr[MEM_AW+1:2]][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  // Read engine: one burst outstanding, next beat fetched on the accepting edge
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state  <= R_IDLE;
      arready  <= 1'b1;
      rvalid   <= 1'b0;
      rlast    <= 1'b0;
      rresp    <= RESP_OKAY;
      rid      <= 4'd0;
      rdata    <= 32'd0;
      rd_addr  <= 32'd0;
      rd_len   <= 8'd0;
      rd_cnt   <= 8'd0;
      rd_burst <= 2'b00;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (arvalid) begin
            rid      <= arid;
            rd_addr  <= araddr;
            rd_len   <= arlen;
            rd_burst <= arburst;
            rd_cnt   <= 8'd0;
            rdata    <= ar_in_c ? mem[araddr[MEM_AW+1:2]] : 32'd0;
            rresp    <= ar_in_c ? RESP_OKAY : RESP_SLVERR;
            rlast    <= (arlen == 8'd0);
            rvalid   <= 1'b1;
            arready  <= 1'b0;
            r_state  <= R_DATA;
          end
        end
        R_DATA: begin
          if (rready) begin
            if (rlast) begin
              rvalid  <= 1'b0;
              rlast   <= 1'b0;
              arready <= 1'b1;
              r_state <= R_IDLE;
            end else begin
              rd_addr <= rd_addr_nxt_c;
              rd_cnt  <= rd_cnt + 8'd1;
              rdata   <= rd_nxt_in_c ? mem[rd_addr_nxt_c[MEM_AW+1:2]] : 32'd0;
              rresp   <= rd_nxt_in_c ? RESP_OKAY : RESP_SLVERR;
              rlast   <= ((rd_cnt + 8'd1) == rd_len);
`ifdef AXI_SRAM_RSTALL_EN
              rvalid  <= 1'b0;
              r_state <= R_GAP;
`endif
            end
          end
        end
        R_GAP: begin
          rvalid  <= 1'b1;
          r_state <= R_DATA;
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  // Write engine: beat count, not wlast, terminates the burst
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      w_state  <= W_IDLE;
      awready  <= 1'b1;
      wready   <= 1'b0;
      bvalid   <= 1'b0;
      bresp    <= RESP_OKAY;
      bid      <= 4'd0;
      wr_id    <= 4'd0;
      wr_addr  <= 32'd0;
      wr_len   <= 8'd0;
      wr_cnt   <= 8'd0;
      wr_burst <= 2'b00;
      wr_err   <= 1'b0;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (awvalid) begin
            wr_id    <= awid;
            wr_addr  <= awaddr;
            wr_len   <= awlen;
            wr_burst <= awburst;
            wr_cnt   <= 8'd0;
            wr_err   <= 1'b0;
            awready  <= 1'b0;
            wready   <= 1'b1;
            w_state  <= W_DATA;
          end
        end
        W_DATA: begin
          if (wr_fire_c) begin
            wr_addr <= wr_addr_nxt_c;
            wr_cnt  <= wr_cnt + 8'd1;
            wr_err  <= wr_err || wr_bad_c;
            if (wr_last_c) begin
              wready  <= 1'b0;
              bvalid  <= 1'b1;
              bid     <= wr_id;
              bresp   <= (wr_err || wr_bad_c) ? RESP_SLVERR : RESP_OKAY;
              w_state <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (bready) begin
            bvalid  <= 1'b0;
            awready <= 1'b1;
            w_state <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_sram_slave.sv
// Scoreboard bench for axi_sram_slave: stimulus pushes expected R beats / B responses,
// monitors on the falling edge compare whatever the DUT presents.
module tb_axi_sram_slave;

  logic        aclk;
  logic        aresetn;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [1:0]  arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;
  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic [1:0]  awlock;
  logic [3:0]  awcache;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;
  logic [3:0]  wid;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } rbeat_t;

  typedef struct packed {
    logic [3:0] id;
    logic [1:0] resp;
  } bexp_t;

  rbeat_t      rq[$];
  bexp_t       bq[$];
  logic [31:0] wd [8];
  logic [3:0]  ws [8];
  logic        wl [8];
  int          tests = 0;
  int          fails = 0;

`ifdef AXI_SRAM_RSTALL_EN
  localparam int RD4_CYC = 8;
`else
  localparam int RD4_CYC = 5;
`endif

  axi_sram_slave dut (
    .aclk(aclk), .aresetn(aresetn),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // R channel monitor: front entry must match while presented, popped on handshake
  always @(negedge aclk) begin
    if (aresetn && rvalid) begin
      if (rq.size() == 0) begin
        chk("r_unexpected_beat", 32'(rq.size()), 32'd1);
      end else begin
        chk("r_id",   32'(rid),   32'(rq[0].id));
        chk("r_data", rdata,      rq[0].data);
        chk("r_resp", 32'(rresp), 32'(rq[0].resp));
        chk("r_last", 32'(rlast), 32'(rq[0].last));
        if (rready) void'(rq.pop_front());
      end
    end
  end

  // B channel monitor
  always @(negedge aclk) begin
    if (aresetn && bvalid) begin
      if (bq.size() == 0) begin
        chk("b_unexpected", 32'(bq.size()), 32'd1);
      end else begin
        chk("b_id",   32'(bid),   32'(bq[0].id));
        chk("b_resp", 32'(bresp), 32'(bq[0].resp));
        if (bready) void'(bq.pop_front());
      end
    end
  end

  task automatic push_r(input logic [3:0] id, input logic [31:0] d, input logic [1:0] resp,
                        input logic last);
    rbeat_t e;
    e.id = id; e.data = d; e.resp = resp; e.last = last;
    rq.push_back(e);
  endtask

  // Drive AR and return #1 after the handshake edge with arvalid dropped
  task automatic ar_issue(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [1:0] burst);
    int t;
    arid = id; araddr = addr; arlen = len; arburst = burst; arvalid = 1'b1;
    t = 0;
    do begin @(negedge aclk); t++; end while (!arready && t < 100);
    chk("ar_accept", 32'(arready), 32'd1);
    @(posedge aclk); #1;
    arvalid = 1'b0;
  endtask

  task automatic rd(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                    input logic [1:0] burst, input logic stall, output int cyc);
    rready = !stall;
    ar_issue(id, addr, len, burst);
    cyc = 1;
    chk("r_first_valid", 32'(rvalid), 32'd1);
    while (!arready && cyc < 1000) begin
      @(posedge aclk); #1;
      cyc++;
      if (stall) rready = !rready;
    end
    rready = 1'b1;
    chk("r_idle", 32'(arready), 32'd1);
    chk("r_drained", 32'(rq.size()), 32'd0);
  endtask

  task automatic wr(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                    input logic [1:0] burst, input logic [1:0] exp_resp, output int cyc);
    int t;
    bexp_t e;
    e.id = id; e.resp = exp_resp;
    bq.push_back(e);
    awid = id; awaddr = addr; awlen = len; awburst = burst; awvalid = 1'b1;
    t = 0;
    do begin @(negedge aclk); t++; end while (!awready && t < 100);
    chk("aw_accept", 32'(awready), 32'd1);
    @(posedge aclk); #1;
    awvalid = 1'b0;
    cyc = 1;
    chk("w_ready_next", 32'(wready), 32'd1);
    for (int b = 0; b <= int'(len); b++) begin
      wvalid = 1'b1; wdata = wd[b]; wstrb = ws[b]; wlast = wl[b];
      @(posedge aclk); #1;
      cyc++;
    end
    wvalid = 1'b0; wlast = 1'b0;
    chk("b_valid_next", 32'(bvalid), 32'd1);
    t = 0;
    while (!awready && t < 100) begin @(posedge aclk); #1; cyc++; t++; end
    chk("w_idle", 32'(awready), 32'd1);
    chk("b_drained", 32'(bq.size()), 32'd0);
  endtask

  task automatic check_reset_values();
    chk("rst_arready", 32'(arready), 32'd1);
    chk("rst_awready", 32'(awready), 32'd1);
    chk("rst_rvalid",  32'(rvalid),  32'd0);
    chk("rst_rlast",   32'(rlast),   32'd0);
    chk("rst_rresp",   32'(rresp),   32'd0);
    chk("rst_rid",     32'(rid),     32'd0);
    chk("rst_rdata",   rdata,        32'd0);
    chk("rst_wready",  32'(wready),  32'd0);
    chk("rst_bvalid",  32'(bvalid),  32'd0);
    chk("rst_bresp",   32'(bresp),   32'd0);
    chk("rst_bid",     32'(bid),     32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish, want finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c;
    aresetn = 1'b0;
    arid = 4'd0; araddr = 32'd0; arlen = 8'd0; arsize = 3'd2; arburst = 2'b01;
    arlock = 2'd0; arcache = 4'd0; arprot = 3'd0; arvalid = 1'b0; rready = 1'b1;
    awid = 4'd0; awaddr = 32'd0; awlen = 8'd0; awsize = 3'd2; awburst = 2'b01;
    awlock = 2'd0; awcache = 4'd0; awprot = 3'd0; awvalid = 1'b0;
    wid = 4'd0; wdata = 32'd0; wstrb = 4'd0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b1;
    repeat (3) @(posedge aclk);
    #1;
    check_reset_values();
    aresetn = 1'b1;
    @(posedge aclk); #1;

    // single-beat write then read back
    wd[0] = 32'hDEADBEEF; ws[0] = 4'hF; wl[0] = 1'b1;
    wr(4'd5, 32'h1FC0_0010, 8'd0, 2'b01, 2'b00, c);
    push_r(4'd1, 32'hDEADBEEF, 2'b00, 1'b1);
    rd(4'd1, 32'h1FC0_0010, 8'd0, 2'b01, 1'b0, c);

    // preload words 0..7 with their index, then stalled INCR read
    for (int k = 0; k < 8; k++) begin wd[k] = 32'(k); ws[k] = 4'hF; wl[k] = (k == 7); end
    wr(4'd2, 32'h1FC0_0000, 8'd7, 2'b01, 2'b00, c);
    chk("w8_cycles", 32'(c), 32'd10);
    for (int k = 0; k < 8; k++) push_r(4'd3, 32'(k), 2'b00, k == 7);
    rd(4'd3, 32'h1FC0_0000, 8'd7, 2'b01, 1'b1, c);

    // strobed burst with misplaced wlast
    for (int k = 0; k < 4; k++) begin wd[k] = 32'h1111_1111; ws[k] = 4'hF; wl[k] = (k == 3); end
    wr(4'd4, 32'h1FC0_0100, 8'd3, 2'b01, 2'b00, c);
    wd[0] = 32'h2222_2222; ws[0] = 4'hF; wl[0] = 1'b0;
    wd[1] = 32'hAABB_CCDD; ws[1] = 4'h1; wl[1] = 1'b0;
    wd[2] = 32'h3333_3333; ws[2] = 4'hC; wl[2] = 1'b1;
    wd[3] = 32'h4444_4444; ws[3] = 4'h0; wl[3] = 1'b0;
    wr(4'd6, 32'h1FC0_0100, 8'd3, 2'b01, 2'b10, c);
    chk("w4_cycles", 32'(c), 32'd6);
    push_r(4'd7, 32'h2222_2222, 2'b00, 1'b0);
    push_r(4'd7, 32'h1111_11DD, 2'b00, 1'b0);
    push_r(4'd7, 32'h3333_1111, 2'b00, 1'b0);
    push_r(4'd7, 32'h1111_1111, 2'b00, 1'b1);
    rd(4'd7, 32'h1FC0_0100, 8'd3, 2'b01, 1'b0, c);

    // out-of-window read and write
    push_r(4'd8, 32'd0, 2'b10, 1'b0);
    push_r(4'd8, 32'd0, 2'b10, 1'b1);
    rd(4'd8, 32'h0000_0000, 8'd1, 2'b01, 1'b0, c);
    wd[0] = 32'h5555_5555; ws[0] = 4'hF; wl[0] = 1'b1;
    wr(4'd9, 32'h0000_0040, 8'd0, 2'b01, 2'b10, c);

    // FIXED write burst lands on one word only
    wd[0] = 32'hCAFE_F00D; ws[0] = 4'hF; wl[0] = 1'b1;
    wr(4'd1, 32'h1FC0_0204, 8'd0, 2'b01, 2'b00, c);
    wd[0] = 32'd1; wd[1] = 32'd2; wd[2] = 32'd3;
    ws[0] = 4'hF; ws[1] = 4'hF; ws[2] = 4'hF;
    wl[0] = 1'b0; wl[1] = 1'b0; wl[2] = 1'b1;
    wr(4'd10, 32'h1FC0_0200, 8'd2, 2'b00, 2'b00, c);
    push_r(4'd11, 32'd3, 2'b00, 1'b0);
    push_r(4'd11, 32'hCAFE_F00D, 2'b00, 1'b1);
    rd(4'd11, 32'h1FC0_0200, 8'd1, 2'b01, 1'b0, c);
    push_r(4'd12, 32'd3, 2'b00, 1'b0);
    push_r(4'd12, 32'd3, 2'b00, 1'b1);
    rd(4'd12, 32'h1FC0_0200, 8'd1, 2'b00, 1'b0, c);

    // burst crossing the top of the window
    wd[0] = 32'h0BAD_F00D; ws[0] = 4'hF; wl[0] = 1'b0;
    wd[1] = 32'h1234_5678; ws[1] = 4'hF; wl[1] = 1'b1;
    wr(4'd13, 32'h1FC0_FFFC, 8'd1, 2'b01, 2'b10, c);
    push_r(4'd14, 32'h0BAD_F00D, 2'b00, 1'b0);
    push_r(4'd14, 32'd0, 2'b10, 1'b1);
    rd(4'd14, 32'h1FC0_FFFC, 8'd1, 2'b01, 1'b0, c);

    // 4-beat read latency
    for (int k = 0; k < 4; k++) push_r(4'd15, 32'(k), 2'b00, k == 3);
    rd(4'd15, 32'h1FC0_0000, 8'd3, 2'b01, 1'b0, c);
    chk("r4_cycles", 32'(c), 32'(RD4_CYC));

    // reset in the middle of a read burst
    for (int k = 0; k < 8; k++) push_r(4'd3, 32'(k), 2'b00, k == 7);
    rready = 1'b1;
    ar_issue(4'd3, 32'h1FC0_0000, 8'd7, 2'b01);
`ifdef AXI_SRAM_RSTALL_EN
    repeat (4) @(posedge aclk);
`else
    repeat (2) @(posedge aclk);
`endif
    #1;
    chk("mid_beat3_data", rdata, 32'd2);
    aresetn = 1'b0;
    #1;
    check_reset_values();
    rq.delete();
    @(posedge aclk); #1;
    aresetn = 1'b1;
    @(posedge aclk); #1;
    push_r(4'd6, 32'd1, 2'b00, 1'b1);
    rd(4'd6, 32'h1FC0_0004, 8'd0, 2'b01, 1'b0, c);
    chk("post_rst_cycles", 32'(c), 32'd2);

    repeat (2) @(posedge aclk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
